maxnet_job_loader: RTL
======================

// Module: maxnet_job_loader
// PURPOSE
//  Upstream front-end of the Maxnet datapath/controller pair. Accepts one job as a 5-word
//  valid/ready stream (epsilon, a1..a4, IEEE-754 single), holds the words stable on the
//  datapath init/epsilon inputs, and pulses start. Waits for finish, then returns the winner
//  word on a valid/ready result port. A watchdog aborts jobs that never converge.
// PARAMETERS
//  DATA_W     32    word width; fixed to 32 for IEEE-754 single
//  TIMEOUT    4096  cycles allowed in WAIT before abort; must be >= 2
//  TO_W       13    watchdog counter width; must satisfy 2**TO_W > TIMEOUT
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  in_data      in   DATA_W  job word; order epsilon, a1, a2, a3, a4
//  in_valid     in   1       in_data valid
//  in_ready     out  1       loader accepts a word this cycle
//  a1_init..a4_init out DATA_W  held activations to datapath
//  epsilon      out  DATA_W  held inhibition weight to datapath
//  start        out  1       one-cycle launch pulse to controller
//  finish       in   1       datapath result-valid (may be level, may stay high)
//  dp_out       in   DATA_W  datapath winner word, sampled when finish accepted
//  res_data     out  DATA_W  captured winner
//  res_valid    out  1       res_data valid
//  res_ready    in   1       consumer takes result
//  res_timeout  out  1       high with res_valid when job aborted by watchdog
//  busy         out  1       high in every state except LOAD
// BEHAVIOUR
//  Reset (async): state LOAD, word count 0, all data outputs 0, start/res_valid/res_timeout 0,
//    armed 0, watchdog 0. Reset asserted in any state abandons the job immediately.
//  States: LOAD -> LAUNCH -> WAIT -> RESULT -> LOAD.
//  LOAD: in_ready = 1. Word transfers on in_valid & in_ready; count 0 -> epsilon,
//    1..4 -> a1..a4. The transfer at count 4 moves to LAUNCH. Count is 3 bits and never wraps.
//  LAUNCH: start = 1 for exactly this one cycle. in_ready = 0. Next state is WAIT. Clear armed
//    and watchdog.
//  WAIT: armed sets on the first cycle finish == 0, which rejects a stale level-high finish
//    from the previous job. When finish & armed, capture dp_out into res_data and go to
//    RESULT with res_timeout = 0. The watchdog increments every WAIT cycle. When it reaches
//    TIMEOUT-1 with no accepted finish, res_data = 0, res_timeout = 1, and go to RESULT.
//    If finish & armed and the timeout occur in the same cycle, finish wins.
//  RESULT: res_valid = 1, and res_data/res_timeout are held. On res_ready, clear res_valid
//    and res_timeout, reset count to 0, and go to LOAD.
//  Output stability: a*_init and epsilon change only on LOAD transfers, and stay stable from
//    LAUNCH through RESULT. in_ready is registered-state-derived, with no combinational path
//    from in_valid.
//  Latency: last input word -> start is 1 cycle. Accepted finish -> res_valid is 1 cycle.
// CONFIGURATION
//  Macro MAXNET_CLAMP_NEG_EN:
//    Defined: on LOAD capture, an activation word with bit31 = 1 (negative or -0.0) is stored
//      as 32'h0000_0000. Epsilon is never clamped.
//    Undefined: all words are stored verbatim.
// STRUCTURE
//  Package maxnet_pkg:
//    State encoding constants: LOAD = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, RESULT = 2'd3.
//    FP_ZERO = 32'h0000_0000 and FP_ONE = 32'h3F80_0000.
//    Word index constants: IDX_EPS = 0, IDX_A1..IDX_A4 = 1..4.
//  Sub-module maxnet_watchdog:
//    Ports: clr, en, and the expire output; TO_W-bit counter sized by TIMEOUT.
//    The FSM and capture registers stay in this module.
// TESTING
//  1 Load 3DCCCCCD, 3F800000, 3F000000, 3E4CCCCD, 3E99999A with in_valid held high ->
//    five transfers, then start high for 1 cycle and a1_init = 3F800000.
//  2 finish held high from the previous job entering WAIT, drops for 1 cycle, then rises with
//    dp_out = 3F19999A -> res_data = 3F19999A and res_timeout = 0.
//  3 finish never asserted -> after TIMEOUT cycles in WAIT, res_valid = 1, res_timeout = 1,
//    res_data = 0.
//  4 res_ready held low for 10 cycles -> res_valid and res_data stable, in_ready = 0
//    throughout. res_ready pulse -> LOAD next cycle.
//  5 rst asserted after the 3rd word, then a full 5-word reload -> fresh job. epsilon equals
//    the new word 0, and no stale start occurs.
//  6 MAXNET_CLAMP_NEG_EN defined, a2 = BF000000 -> a2_init = 00000000. Undefined -> BF000000.

Source files
------------

// File: rtl/maxnet_pkg.sv
// Shared types and constants for the Maxnet job loader.
// The feature macro MAXNET_CLAMP_NEG_EN is consumed by maxnet_job_loader.
package maxnet_pkg;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RESULT = 2'd3
   } state_t;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

   localparam logic [2:0] IDX_EPS = 3'd0;
   localparam logic [2:0] IDX_A1  = 3'd1;
   localparam logic [2:0] IDX_A2  = 3'd2;
   localparam logic [2:0] IDX_A3  = 3'd3;
   localparam logic [2:0] IDX_A4  = 3'd4;

   // Sign bit set covers both negative values and -0.0.
   function automatic logic [31:0] clamp_neg(input logic [31:0] i_word);
      return i_word[31] ? FP_ZERO : i_word;
   endfunction

endpackage

// File: rtl/maxnet_watchdog.sv
// Cycle-count watchdog: counts enabled cycles after a clear and flags the
// last allowed cycle (count == TIMEOUT-1).
module maxnet_watchdog #(
   parameter int unsigned TIMEOUT = 4096,
   parameter int unsigned TO_W    = 13
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != LAST)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/maxnet_job_loader.sv
// Maxnet job front-end: loads epsilon/a1..a4, launches, waits for finish, returns the winner.
// Define MAXNET_CLAMP_NEG_EN to store negative activation words as +0.0.
module maxnet_job_loader
   import maxnet_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 4096,
   parameter int unsigned TO_W    = 13
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [DATA_W-1:0] i_in_data,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   output logic [DATA_W-1:0] o_a1_init,
   output logic [DATA_W-1:0] o_a2_init,
   output logic [DATA_W-1:0] o_a3_init,
   output logic [DATA_W-1:0] o_a4_init,
   output logic [DATA_W-1:0] o_epsilon,
   output logic              o_start,
   input  logic              i_finish,
   input  logic [DATA_W-1:0] i_dp_out,
   output logic [DATA_W-1:0] o_res_data,
   output logic              o_res_valid,
   input  logic              i_res_ready,
   output logic              o_res_timeout,
   output logic              o_busy
);

   state_t            r_state;
   state_t            w_state_next;
   logic [2:0]        r_count;
   logic              r_armed;
   logic [DATA_W-1:0] r_eps;
   logic [DATA_W-1:0] r_a1;
   logic [DATA_W-1:0] r_a2;
   logic [DATA_W-1:0] r_a3;
   logic [DATA_W-1:0] r_a4;
   logic [DATA_W-1:0] r_res_data;
   logic              r_res_timeout;

   logic              w_xfer;
   logic              w_accept;
   logic              w_expire;
   logic [DATA_W-1:0] w_act;

   assign w_xfer   = (r_state == LOAD) && i_in_valid;
   // Armed only after finish has been seen low, so a stale high level is ignored.
   assign w_accept = (r_state == WAIT) && i_finish && r_armed;

`ifdef MAXNET_CLAMP_NEG_EN
   assign w_act = clamp_neg(i_in_data);
`else
   assign w_act = i_in_data;
`endif

   maxnet_watchdog #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_watchdog (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clr    (r_state == LAUNCH),
      .i_en     (r_state == WAIT),
      .o_expire (w_expire)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= LOAD;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         LOAD:    if (w_xfer && (r_count == IDX_A4)) w_state_next = LAUNCH;
         LAUNCH:  w_state_next = WAIT;
         WAIT:    if (w_accept || w_expire) w_state_next = RESULT;
         RESULT:  if (i_res_ready) w_state_next = LOAD;
         default: w_state_next = LOAD;
      endcase
   end

   always_comb begin
      o_in_ready  = (r_state == LOAD);
      o_start     = (r_state == LAUNCH);
      o_res_valid = (r_state == RESULT);
      o_busy      = (r_state != LOAD);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count       <= IDX_EPS;
         r_armed       <= 1'b0;
         r_eps         <= '0;
         r_a1          <= '0;
         r_a2          <= '0;
         r_a3          <= '0;
         r_a4          <= '0;
         r_res_data    <= '0;
         r_res_timeout <= 1'b0;
      end else begin
         case (r_state)
            LOAD: begin
               if (w_xfer) begin
                  case (r_count)
                     IDX_EPS: r_eps <= i_in_data;
                     IDX_A1:  r_a1  <= w_act;
                     IDX_A2:  r_a2  <= w_act;
                     IDX_A3:  r_a3  <= w_act;
                     IDX_A4:  r_a4  <= w_act;
                     default: ;
                  endcase
                  if (r_count != IDX_A4) r_count <= r_count + 3'd1;
               end
            end
            LAUNCH: r_armed <= 1'b0;
            WAIT: begin
               if (!i_finish) r_armed <= 1'b1;
               if (w_accept) begin
                  r_res_data    <= i_dp_out;
                  r_res_timeout <= 1'b0;
               end else if (w_expire) begin
                  r_res_data    <= '0;
                  r_res_timeout <= 1'b1;
               end
            end
            RESULT: begin
               if (i_res_ready) begin
                  r_res_timeout <= 1'b0;
                  r_count       <= IDX_EPS;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_epsilon     = r_eps;
   assign o_a1_init     = r_a1;
   assign o_a2_init     = r_a2;
   assign o_a3_init     = r_a3;
   assign o_a4_init     = r_a4;
   assign o_res_data    = r_res_data;
   assign o_res_timeout = r_res_timeout;

endmodule
